mux4b_rr_arb_ctrl: RTL

//  Round-robin arbiter/sequencer that shares one 4:1 WIDTH-bit enabled mux among

---
 rtl/mux4b_rr_arb_ctrl_pkg.sv | 25 ++
 rtl/mux4b_rr_arb_ctrl_if.sv | 32 +++
 rtl/mux4b_rr_arb_ctrl_mux.sv | 27 ++
 rtl/mux4b_rr_arb_ctrl_pick.sv | 29 ++
 rtl/mux4b_rr_arb_ctrl.sv | 109 ++++++++++
 5 files changed

// File: rtl/mux4b_rr_arb_ctrl_pkg.sv
// Shared types, constants and helpers for the 4-way round-robin mux arbiter.
package mux4b_rr_arb_ctrl_pkg;

  localparam int unsigned ReqN = 4;

  // Grant FSM: idle with no owner, or busy serving one requester.
  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Beat counter width; never narrower than one bit, even for single-beat bursts.
  function automatic int unsigned cnt_width(input int unsigned burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

  // Mux leg index to one-hot grant vector.
  function automatic logic [ReqN-1:0] idx2onehot(input logic [1:0] idx);
    logic [ReqN-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4b_rr_arb_ctrl_if.sv
// Requester-side bus of the shared mux: request/data legs in, grant/mux controls
// and the registered beat out.
interface mux4b_rr_arb_ctrl_if
  import mux4b_rr_arb_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);

  logic [ReqN-1:0]  req;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [ReqN-1:0]  gnt;
  logic [1:0]       sel;
  logic             enable;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  // Requester side.
  modport master (
    output req, a, b, c, d,
    input  gnt, sel, enable, out, out_valid
  );

  // Arbiter side.
  modport slave (
    input  req, a, b, c, d,
    output gnt, sel, enable, out, out_valid
  );

endinterface

// File: rtl/mux4b_rr_arb_ctrl_mux.sv
// Enabled 4:1 mux datapath; drives zero when disabled.
module mux4b_4to1_en #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [1:0]       sel_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] y_o
);

  // Leg select gated by enable.
  always_comb begin
    y_o = '0;
    if (enable_i) begin
      unique case (sel_i)
        2'd0:    y_o = a_i;
        2'd1:    y_o = b_i;
        2'd2:    y_o = c_i;
        default: y_o = d_i;
      endcase
    end
  end

endmodule

// File: rtl/mux4b_rr_arb_ctrl_pick.sv
// Combinational round-robin picker: searches rr_ptr+1 .. rr_ptr+4 (mod 4), so the
// last winner is lowest priority.
module rr_pick4
  import mux4b_rr_arb_ctrl_pkg::*;
(
  input  logic [ReqN-1:0] req_i,
  input  logic [1:0]      rr_ptr_i,
  output logic [1:0]      idx_o,
  output logic            any_o
);

  // First set request after the pointer wins.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    found = 1'b0;
    cand  = '0;
    idx_o = '0;
    for (int unsigned k = 1; k <= ReqN; k++) begin
      cand = rr_ptr_i + 2'(k);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mux4b_rr_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one enabled 4:1 mux among four requesters,
// with bounded bursts, zero-bubble handover and a registered output beat.
module mux4b_rr_arb_ctrl
  import mux4b_rr_arb_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input logic                clk,
  input logic                rst,
  mux4b_rr_arb_ctrl_if.slave bus
);

  localparam int unsigned    CntW     = cnt_width(BURST_LEN);
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

  state_e           state_q;
  logic [ReqN-1:0]  gnt_q;
  logic [1:0]       sel_q;
  logic             enable_q;
  logic [1:0]       rr_ptr_q;
  logic [CntW-1:0]  beat_cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;

  logic             beat;
  logic             rearb;
  logic [1:0]       pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] mux_y;

  rr_pick4 u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  mux4b_4to1_en #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .c_i      (bus.c),
    .d_i      (bus.d),
    .sel_i    (sel_q),
    .enable_i (enable_q),
    .y_o      (mux_y)
  );

  // A beat is a granted leg that is still requesting; otherwise decide whether to re-arbitrate.
  always_comb begin
    beat  = enable_q & bus.req[sel_q];
    rearb = 1'b0;
    unique case (state_q)
      StIdle:  rearb = 1'b1;
      StBusy:  rearb = !beat || (beat_cnt_q == LastBeat);
      default: rearb = 1'b1;
    endcase
  end

  // Grant FSM: arbitrate from idle or at grant end; otherwise count beats of the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      sel_q      <= '0;
      enable_q   <= 1'b0;
      rr_ptr_q   <= 2'd3;
      beat_cnt_q <= '0;
    end else if (rearb) begin
      beat_cnt_q <= '0;
      if (pick_any) begin
        state_q  <= StBusy;
        gnt_q    <= idx2onehot(pick_idx);
        sel_q    <= pick_idx;
        enable_q <= 1'b1;
        rr_ptr_q <= pick_idx;
      end else begin
        // sel keeps its last value while idle.
        state_q  <= StIdle;
        gnt_q    <= '0;
        enable_q <= 1'b0;
      end
    end else begin
      beat_cnt_q <= beat_cnt_q + CntW'(1);
    end
  end

  // Capture the mux output on every beat; out holds between beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (beat) begin
      out_q       <= mux_y;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.enable    = enable_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule
